// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Imported by the top level so the FSM encoding and counter sizing live in one place.
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of digit steps needed for one full-width operation.
   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = width / digit;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_n_digit_adder.sv
// DIGIT-bit combinational ripple adder built from full-adder bit equations.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock, LS digit first,
// with a start/busy/done handshake and carry/overflow flags on completion.
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_n: illegal WIDTH/DIGIT combination");
   end

   state_t           state, state_nx;
   logic             accept, last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa, opb, res;
   logic             carry;

   logic [DIGIT-1:0]       dsum;
   logic                   dco, dcm;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_nx;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (opa[DIGIT-1:0]),
      .y     (opb[DIGIT-1:0]),
      .ci    (carry),
      .s     (dsum),
      .co    (dco),
      .c_msb (dcm)
   );

   // New digit enters at the top; after N steps the word is fully aligned.
   assign res_cat = {dsum, res};
   assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];
   assign busy    = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every variable gets a default before the case so no latch can be inferred.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept   = 1'b1;
            state_nx = RUN;
         end
         RUN: if (cnt == LAST_CNT) begin
            last     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
         end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            res   <= res_nx;
            carry <= dco;
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum  <= res_nx;
               cout <= dco;
               ovf  <= dcm ^ dco;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: directed cases on (16,4) plus
// randomized sweeps on (16,4), (16,1), (16,16) and (8,2) against an arithmetic model.
module tb_serial_adder_n;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start_v [4];
   logic [15:0] a_v     [4];
   logic [15:0] b_v     [4];
   logic        cin_v   [4];
   logic        sub_v   [4];

   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic        cout0, cout1, cout2, cout3;
   logic        ovf0,  ovf1,  ovf2,  ovf3;
   logic [15:0] sum0,  sum1,  sum2;
   logic [7:0]  sum3;

   int n_vec = 0;
   int n_bad = 0;

   serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_16_4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .cin(cin_v[0]), .sub(sub_v[0]), .busy(busy0), .done(done0), .sum(sum0),
      .cout(cout0), .ovf(ovf0));

   serial_adder_n #(.WIDTH(16), .DIGIT(1)) u_16_1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .cin(cin_v[1]), .sub(sub_v[1]), .busy(busy1), .done(done1), .sum(sum1),
      .cout(cout1), .ovf(ovf1));

   serial_adder_n #(.WIDTH(16), .DIGIT(16)) u_16_16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
      .cin(cin_v[2]), .sub(sub_v[2]), .busy(busy2), .done(done2), .sum(sum2),
      .cout(cout2), .ovf(ovf2));

   serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_8_2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3][7:0]), .b(b_v[3][7:0]),
      .cin(cin_v[3]), .sub(sub_v[3]), .busy(busy3), .done(done3), .sum(sum3),
      .cout(cout3), .ovf(ovf3));

   function automatic int w_of(input int i);
      return (i == 3) ? 8 : 16;
   endfunction

   function automatic int n_of(input int i);
      case (i)
         0: return 4;
         1: return 16;
         2: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic o_busy(input int i);
      case (i) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
   endfunction
   function automatic logic o_done(input int i);
      case (i) 0: return done0; 1: return done1; 2: return done2; default: return done3; endcase
   endfunction
   function automatic logic o_cout(input int i);
      case (i) 0: return cout0; 1: return cout1; 2: return cout2; default: return cout3; endcase
   endfunction
   function automatic logic o_ovf(input int i);
      case (i) 0: return ovf0; 1: return ovf1; 2: return ovf2; default: return ovf3; endcase
   endfunction
   function automatic logic [15:0] o_sum(input int i);
      case (i) 0: return sum0; 1: return sum1; 2: return sum2; default: return {8'h00, sum3}; endcase
   endfunction

   // Reference: plain integer arithmetic, signed range check for overflow.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub,
                                 output logic [15:0] s, output logic co, output logic ov);
      longint one, mask, half, ua, ub, sa, sb, full, sres;
      one  = 1;
      mask = (one << w) - 1;
      half = one << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - (one << w) : ua;
      sb   = (ub >= half) ? ub - (one << w) : ub;
      if (sub) begin
         full = ua - ub;
         co   = (ua >= ub);
         sres = sa - sb;
      end else begin
         full = ua + ub + longint'(cin);
         co   = (full > mask);
         sres = sa + sb + longint'(cin);
      end
      s  = 16'(full & mask);
      ov = (sres >= half) || (sres < -half);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or after 64 edges).
   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input bit poke,
                         output int edges, output int busy_cnt,
                         output logic [1:0] first_bd, output bit held);
      logic [15:0] s0;
      logic        c0, o0;
      s0 = o_sum(idx); c0 = o_cout(idx); o0 = o_ovf(idx);
      held = 1'b1; busy_cnt = 0; edges = 0; first_bd = 2'b00;
      a_v[idx] = a; b_v[idx] = b; cin_v[idx] = cin; sub_v[idx] = sub;
      start_v[idx] = 1'b1;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         start_v[idx] = poke && (edges == 2);
         if (poke && edges == 2) begin
            a_v[idx] = 16'hAAAA;
            b_v[idx] = 16'hAAAA;
         end
         if (edges == 1) first_bd = {o_busy(idx), o_done(idx)};
         if (o_busy(idx)) busy_cnt++;
         if (!o_done(idx) && (o_sum(idx) !== s0 || o_cout(idx) !== c0 || o_ovf(idx) !== o0))
            held = 1'b0;
      end while (!o_done(idx) && edges < 64);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({o_busy(i), o_done(i), o_cout(i), o_ovf(i), o_sum(i)} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_state inst=%0d busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     i, o_busy(i), o_done(i), o_cout(i), o_ovf(i), o_sum(i));
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int e, bc; logic [1:0] fb; bit h;
      run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, e, bc, fb, h);
      n_vec++;
      if ({sum0, cout0, ovf0} !== {16'h2233, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL basic_add sum=%h cout=%b ovf=%b, want 2233 0 0", sum0, cout0, ovf0);
      end
      n_vec++;
      if (e !== 5 || bc !== 4) begin
         n_bad++;
         $display("FAIL basic_latency edges=%0d busy_cycles=%0d, want 5 and 4", e, bc);
      end
      n_vec++;
      if (!h) begin
         n_bad++;
         $display("FAIL basic_hold outputs changed before done, want held");
      end
      @(negedge clk);
      n_vec++;
      if (done0 !== 1'b0 || sum0 !== 16'h2233) begin
         n_bad++;
         $display("FAIL done_pulse done=%b sum=%h, want 0 2233", done0, sum0);
      end
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] s;
      logic        co, ov;
   } vec_t;

   task automatic test_carry_ovf();
      vec_t tbl [4];
      int e, bc; logic [1:0] fb; bit h;
      tbl[0] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, s:16'h0000, co:1'b1, ov:1'b0};
      tbl[1] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, s:16'h8000, co:1'b0, ov:1'b1};
      tbl[2] = '{a:16'h0005, b:16'h0007, cin:1'b1, sub:1'b1, s:16'hFFFE, co:1'b0, ov:1'b0};
      tbl[3] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, s:16'h7FFF, co:1'b1, ov:1'b1};
      for (int i = 0; i < 4; i++) begin
         run_op(0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0, e, bc, fb, h);
         n_vec++;
         if ({sum0, cout0, ovf0} !== {tbl[i].s, tbl[i].co, tbl[i].ov} || e !== 5) begin
            n_bad++;
            $display("FAIL flags_case%0d sum=%h cout=%b ovf=%b edges=%0d, want %h %b %b 5",
                     i, sum0, cout0, ovf0, e, tbl[i].s, tbl[i].co, tbl[i].ov);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_handshake();
      int e, bc; logic [1:0] fb; bit h;
      run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, e, bc, fb, h);
      n_vec++;
      if ({sum0, cout0, ovf0} !== {16'h2233, 1'b0, 1'b0} || e !== 5 || bc !== 4) begin
         n_bad++;
         $display("FAIL start_while_busy sum=%h cout=%b ovf=%b edges=%0d busy=%0d, want 2233 0 0 5 4",
                  sum0, cout0, ovf0, e, bc);
      end
      // Still in the done cycle: this start must be taken immediately.
      run_op(0, 16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, e, bc, fb, h);
      n_vec++;
      if (sum0 !== 16'h0123 || e !== 5) begin
         n_bad++;
         $display("FAIL back_to_back sum=%h gap=%0d, want 0123 5", sum0, e);
      end
      n_vec++;
      if (fb !== 2'b10 || !h) begin
         n_bad++;
         $display("FAIL back_to_back_edge busy_done=%b held=%0d, want 10 1", fb, h);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int e, bc; logic [1:0] fb; bit h;
      bit saw_done;
      a_v[0] = 16'h4444; b_v[0] = 16'h1111; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy0, done0, cout0, ovf0, sum0} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset_abort busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                  busy0, done0, cout0, ovf0, sum0);
      end
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done0 !== 1'b0) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done0 !== 1'b0) saw_done = 1'b1;
      end
      n_vec++;
      if (saw_done) begin
         n_bad++;
         $display("FAIL reset_no_done done pulsed after abort, want no pulse");
      end
      run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, e, bc, fb, h);
      n_vec++;
      if (sum0 !== 16'h0002 || e !== 5) begin
         n_bad++;
         $display("FAIL after_reset sum=%h edges=%0d, want 0002 5", sum0, e);
      end
      @(negedge clk);
   endtask

   task automatic test_sweep();
      int e, bc; logic [1:0] fb; bit h;
      logic [15:0] ra, rb, es;
      logic rc, rs, ec, eo;
      for (int idx = 0; idx < 4; idx++) begin
         for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(w_of(idx), ra, rb, rc, rs, es, ec, eo);
            run_op(idx, ra, rb, rc, rs, 1'b0, e, bc, fb, h);
            n_vec++;
            if ({o_sum(idx), o_cout(idx), o_ovf(idx)} !== {es, ec, eo}) begin
               n_bad++;
               $display("FAIL sweep_result inst=%0d a=%h b=%h cin=%b sub=%b got %h %b %b, want %h %b %b",
                        idx, ra, rb, rc, rs, o_sum(idx), o_cout(idx), o_ovf(idx), es, ec, eo);
            end
            n_vec++;
            if (e !== n_of(idx) + 1 || bc !== n_of(idx) || !h) begin
               n_bad++;
               $display("FAIL sweep_timing inst=%0d edges=%0d busy=%0d held=%0d, want %0d %0d 1",
                        idx, e, bc, h, n_of(idx) + 1, n_of(idx));
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         start_v[i] = 1'b0;
         a_v[i]     = '0;
         b_v[i]     = '0;
         cin_v[i]   = 1'b0;
         sub_v[i]   = 1'b0;
      end
      test_reset();
      test_basic();
      test_carry_ovf();
      test_handshake();
      test_reset_abort();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
